// File: rtl/msu_pkg.sv
// Shared types and defaults for the squarer output normalizer.
// Holds the FSM state encoding and the default datapath geometry.
`ifndef MOD_LEN_DEF
`define MOD_LEN_DEF 1024
`endif

package msu_pkg;

    localparam int MOD_LEN_D   = `MOD_LEN_DEF;
    localparam int WORD_LEN_D  = 16;
    localparam int COEF_BITS_D = 2 * WORD_LEN_D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Carry out of a coefficient plus the previous carry never needs more
    // than the coefficient's excess over one digit, plus one bit.
    function automatic int ovf_bits(input int coef_bits, input int word_len);
        return coef_bits - word_len + 1;
    endfunction

endpackage

// File: rtl/carry_chunk.sv
// Combinational ripple of a carry through a group of coefficients,
// producing one WORD_LEN digit per coefficient and the outgoing carry.
module carry_chunk
    import msu_pkg::*;
#(
    parameter int WORD_LEN  = WORD_LEN_D,
    parameter int COEF_BITS = COEF_BITS_D,
    parameter int NUM_COEFS = 4,
    parameter int OVF_BITS  = ovf_bits(COEF_BITS, WORD_LEN)
) (
    input  logic [NUM_COEFS*COEF_BITS-1:0] coefs,
    input  logic [OVF_BITS-1:0]            carry_in,
    output logic [NUM_COEFS*WORD_LEN-1:0]  digits,
    output logic [OVF_BITS-1:0]            carry_out
);

    localparam int ACC_BITS = COEF_BITS + 1;

    logic [ACC_BITS-1:0] acc;
    logic [OVF_BITS-1:0] carry;

    always_comb begin
        acc    = '0;
        carry  = carry_in;
        digits = '0;
        for (int i = 0; i < NUM_COEFS; i++) begin
            acc = {1'b0, coefs[i*COEF_BITS +: COEF_BITS]}
                + ACC_BITS'(carry);
            digits[i*WORD_LEN +: WORD_LEN] = acc[WORD_LEN-1:0];
            carry = acc[ACC_BITS-1:WORD_LEN];
        end
        carry_out = carry;
    end

endmodule

// File: rtl/sq_out_normalizer.sv
// Converts a redundant squarer output (wide coefficients) into a plain
// binary result, resolving carries a few coefficients per clock.
`ifndef MOD_LEN_DEF
`define MOD_LEN_DEF 1024
`endif

module sq_out_normalizer
    import msu_pkg::*;
#(
    parameter int MOD_LEN         = `MOD_LEN_DEF,
    parameter int WORD_LEN        = WORD_LEN_D,
    parameter int NUM_ELEMENTS    = MOD_LEN / WORD_LEN,
    parameter int COEF_BITS       = 2 * WORD_LEN,
    parameter int COEFS_PER_CYCLE = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_ELEMENTS*COEF_BITS-1:0] coef_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MOD_LEN-1:0]                result,
    output logic [COEF_BITS-WORD_LEN:0]       overflow
);

    localparam int NUM_CHUNKS = NUM_ELEMENTS / COEFS_PER_CYCLE;
    localparam int OVF_BITS   = ovf_bits(COEF_BITS, WORD_LEN);
    localparam int CHUNK_CB   = COEFS_PER_CYCLE * COEF_BITS;
    localparam int CHUNK_WL   = COEFS_PER_CYCLE * WORD_LEN;
    localparam int IDX_W      = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
    localparam int IN_W       = NUM_ELEMENTS * COEF_BITS;

    if (NUM_ELEMENTS % COEFS_PER_CYCLE != 0) begin : g_bad_chunking
        $error("NUM_ELEMENTS must be a multiple of COEFS_PER_CYCLE");
    end
    if (NUM_ELEMENTS * WORD_LEN != MOD_LEN) begin : g_bad_geometry
        $error("NUM_ELEMENTS*WORD_LEN must equal MOD_LEN");
    end

    state_t state, state_nxt;

    logic [IN_W-1:0]     coef_q;
    logic [OVF_BITS-1:0] carry_q;
    logic [IDX_W-1:0]    idx_q;
    logic [MOD_LEN-1:0]  result_q;
    logic [OVF_BITS-1:0] overflow_q;

    logic [CHUNK_WL-1:0]         digits;
    logic [OVF_BITS-1:0]         carry_nxt;
    logic                        last_chunk;
    logic [MOD_LEN+CHUNK_WL-1:0] result_cat;
    logic [MOD_LEN+CHUNK_WL-1:0] result_sh;

    carry_chunk #(
        .WORD_LEN  (WORD_LEN),
        .COEF_BITS (COEF_BITS),
        .NUM_COEFS (COEFS_PER_CYCLE),
        .OVF_BITS  (OVF_BITS)
    ) u_chunk (
        .coefs     (coef_q[CHUNK_CB-1:0]),
        .carry_in  (carry_q),
        .digits    (digits),
        .carry_out (carry_nxt)
    );

    assign last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));

    // Chunks enter at the top and slide down, so after the final chunk
    // the lowest chunk ends up at bit 0.
    assign result_cat = {digits, result_q};
    assign result_sh  = result_cat >> CHUNK_WL;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coef_q     <= '0;
            carry_q    <= '0;
            idx_q      <= '0;
            result_q   <= '0;
            overflow_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        coef_q  <= coef_in;
                        carry_q <= '0;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    coef_q   <= coef_q >> CHUNK_CB;
                    carry_q  <= carry_nxt;
                    idx_q    <= idx_q + 1'b1;
                    result_q <= result_sh[MOD_LEN-1:0];
                    if (last_chunk) begin
                        overflow_q <= carry_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sq_out_normalizer.sv
// Self-checking bench for sq_out_normalizer: fixed-pattern table,
// handshake/reset corner sequences and random vectors vs a sum model.
module tb_sq_out_normalizer;

    localparam int ML  = 1024;
    localparam int WL  = 16;
    localparam int NE  = ML / WL;
    localparam int CB  = 2 * WL;
    localparam int OB  = CB - WL + 1;
    localparam int NCH = NE / 4;
    localparam int IW  = NE * CB;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] coef_in;
    logic          out_valid;
    logic          out_ready;
    logic [ML-1:0] result;
    logic [OB-1:0] overflow;

    int checks = 0;
    int errors = 0;

    sq_out_normalizer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef_in   (coef_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CB-1:0] fill;
        logic [WL-1:0] d0;
        logic [WL-1:0] d1;
        logic [WL-1:0] drest;
        logic [OB-1:0] ovf;
    } vec_t;

    task automatic chk(input string name, input logic [ML-1:0] act,
                       input logic [ML-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] fill_vec(input logic [CB-1:0] f);
        logic [IW-1:0] v;
        for (int j = 0; j < NE; j++) v[j*CB +: CB] = f;
        return v;
    endfunction

    // Reference: the full integer sum of coef[j] * 2^(WL*j).
    task automatic model(input logic [IW-1:0] v, output logic [ML-1:0] r,
                         output logic [OB-1:0] o);
        logic [ML+OB-1:0] s;
        s = '0;
        for (int j = 0; j < NE; j++)
            s = s + ((ML+OB)'(v[j*CB +: CB]) << (WL * j));
        r = s[ML-1:0];
        o = s[ML+OB-1:ML];
    endtask

    task automatic send(input logic [IW-1:0] v, output int lat);
        coef_in  = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_in_ready"}, ML'(in_ready), ML'(1));
        chk({name, "_out_valid"}, ML'(out_valid), ML'(0));
    endtask

    task automatic run_check(input string name, input logic [IW-1:0] v,
                             input logic [ML-1:0] er, input logic [OB-1:0] eo);
        int lat;
        send(v, lat);
        chk({name, "_latency"}, ML'(lat), ML'(NCH));
        chk({name, "_result"}, result, er);
        chk({name, "_overflow"}, ML'(overflow), ML'(eo));
        consume(name);
    endtask

    vec_t          tbl[4];
    logic [ML-1:0] er;
    logic [OB-1:0] eo;
    logic [ML-1:0] held;
    logic [IW-1:0] rv;
    int            lat;

    initial begin
        tbl[0] = '{32'h0000_0000, 16'h0000, 16'h0000, 16'h0000, 17'h00000};
        tbl[1] = '{32'h0000_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 17'h00000};
        tbl[2] = '{32'h0001_0000, 16'h0000, 16'h0001, 16'h0001, 17'h00001};
        tbl[3] = '{32'hFFFF_FFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF, 17'h10000};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        coef_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", ML'(in_ready), ML'(1));
        chk("rst_out_valid", ML'(out_valid), ML'(0));
        chk("rst_result", result, '0);
        chk("rst_overflow", ML'(overflow), '0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < NE; j++)
                er[j*WL +: WL] = (j == 0) ? tbl[i].d0 :
                                 (j == 1) ? tbl[i].d1 : tbl[i].drest;
            run_check($sformatf("tbl%0d", i), fill_vec(tbl[i].fill),
                      er, tbl[i].ovf);
        end

        // Back-pressure in DONE with a noisy input port.
        send(fill_vec(32'h1234_5678), lat);
        chk("bp_latency", ML'(lat), ML'(NCH));
        model(fill_vec(32'h1234_5678), er, eo);
        chk("bp_result0", result, er);
        held = result;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            coef_in  = fill_vec($urandom);
            @(posedge clk); #1;
            chk("bp_stable", result, held);
            chk("bp_in_ready", ML'(in_ready), ML'(0));
            chk("bp_out_valid", ML'(out_valid), ML'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_ready", ML'(in_ready), ML'(1));
        chk("bp_release_valid", ML'(out_valid), ML'(0));

        // Reset while chunk 7 is in flight.
        coef_in  = fill_vec(32'h0001_0000);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("mid_rst_out_valid", ML'(out_valid), ML'(0));
        chk("mid_rst_in_ready", ML'(in_ready), ML'(1));
        chk("mid_rst_result", result, '0);
        chk("mid_rst_overflow", ML'(overflow), '0);
        repeat (NCH + 2) begin
            @(posedge clk); #1;
            chk("mid_rst_no_stale", ML'(out_valid), ML'(0));
        end
        model(fill_vec(32'hFFFF_FFFF), er, eo);
        run_check("post_rst", fill_vec(32'hFFFF_FFFF), er, eo);

        // Random vectors, some biased toward maximal coefficients.
        for (int n = 0; n < 12; n++) begin
            for (int j = 0; j < NE; j++)
                rv[j*CB +: CB] = (n % 3 == 0 && $urandom_range(1) == 1)
                                 ? 32'hFFFF_FFFF : 32'($urandom);
            model(rv, er, eo);
            run_check($sformatf("rnd%0d", n), rv, er, eo);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sq_out_normalizer.md
SQ_OUT_NORMALIZER -- requirements
Module: sq_out_normalizer

Interface
REQ-001 SHALL have parameter MOD_LEN, default `MOD_LEN_DEF (1024): modulus width in bits.
REQ-002 SHALL have parameter WORD_LEN, default 16: weight step per coefficient (coef j has weight 2^(WORD_LEN*j)).
REQ-003 SHALL have parameter NUM_ELEMENTS, default MOD_LEN/WORD_LEN: coefficient count.
REQ-004 SHALL have parameter COEF_BITS, default 2*WORD_LEN: width of each incoming coefficient slot.
REQ-005 SHALL have parameter COEFS_PER_CYCLE, default 4: coefficients carry-propagated per clock.
REQ-006 SHALL have derived localparams NUM_CHUNKS = NUM_ELEMENTS/COEFS_PER_CYCLE and OVF_BITS = COEF_BITS-WORD_LEN+1.
REQ-007 clk  input  1  sole clock, all logic on posedge.
REQ-008 reset  input  1  synchronous, active-high.
REQ-009 in_valid  input  1  coef_in holds a squarer output vector.
REQ-010 in_ready  output  1  block can accept a vector.
REQ-011 coef_in  input  NUM_ELEMENTS*COEF_BITS  coefficient j in bits [j*COEF_BITS +: COEF_BITS], unsigned.
REQ-012 out_valid  output  1  result/overflow hold a normalized value.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 result  output  MOD_LEN  low MOD_LEN bits of sum(coef[j]*2^(WORD_LEN*j)).
REQ-015 overflow  output  OVF_BITS  bits of that sum at and above 2^MOD_LEN.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE: on in_valid=1 SHALL capture coef_in into an internal register, clear carry and chunk index, and go to RUN.
REQ-019 RUN: each cycle SHALL process chunk k (coefficients k*COEFS_PER_CYCLE .. +COEFS_PER_CYCLE-1) in ascending order: acc = coef + carry; digit = acc[WORD_LEN-1:0]; carry = acc >> WORD_LEN; digit written to result[j*WORD_LEN +: WORD_LEN].
REQ-020 Carry register SHALL be OVF_BITS wide; no intermediate value SHALL be truncated (acc is COEF_BITS+1 bits).
REQ-021 After chunk NUM_CHUNKS-1 SHALL load overflow with final carry and go to DONE; out_valid SHALL be high exactly NUM_CHUNKS edges after the accepting edge (16 at defaults).
REQ-022 DONE: result and overflow SHALL hold stable while out_ready=0; on out_ready=1 SHALL go to IDLE at the next edge.
REQ-023 in_valid in RUN or DONE SHALL be ignored and SHALL not disturb the in-flight computation.
REQ-024 In-flight accept and output handshake SHALL never occur in the same cycle (no bypass); throughput is one vector per NUM_CHUNKS+2 cycles minimum.
REQ-025 Elaboration SHALL fail if NUM_ELEMENTS mod COEFS_PER_CYCLE != 0 or NUM_ELEMENTS*WORD_LEN != MOD_LEN.

Reset
REQ-026 On reset=1 at a clock edge, SHALL enter IDLE; out_valid=0, in_ready=1 after that edge; result, overflow, carry, chunk index SHALL be 0.
REQ-027 Reset in RUN or DONE SHALL discard the in-flight vector; no stale out_valid SHALL follow.
REQ-028 Reset SHALL dominate a simultaneous in_valid or out_ready.

Structure
REQ-029 State enum, MOD_LEN/WORD_LEN/COEF_BITS defaults and OVF_BITS derivation SHALL live in shared package msu_pkg.
REQ-030 Chunk carry chain SHALL be a combinational sub-module carry_chunk (inputs COEFS_PER_CYCLE coefficients + carry_in; outputs digits + carry_out), instantiated once.

Verification
REQ-031 All coef=0 -> result=0, overflow=0, out_valid on 16th edge after accept.
REQ-032 All coef=0x0000FFFF -> result=all ones, overflow=0.
REQ-033 All coef=0x00010000 -> digit0=0x0000, digits 1..63=0x0001, overflow=1.
REQ-034 All coef=0xFFFFFFFF -> digit0=0xFFFF, digit1=0xFFFE, digits 2..63=0xFFFF, overflow=0x10000.
REQ-035 out_ready=0 for 5 cycles in DONE with in_valid=1 and changing coef_in -> result stable, in_ready=0; then out_ready=1 -> IDLE next edge, in_ready=1.
REQ-036 Reset asserted during RUN chunk 7 -> out_valid=0, in_ready=1 after edge; next vector (REQ-034 data) yields REQ-034 result.
